bp_rom_loader: RTL and testbench

// - Consumes the hps_io ROM download stream (ioctl_*, index 0) and turns each 16-bit word into two byte writes.
// - Routes each byte to one of four ROM regions: CPU, FG gfx, BG/sprite gfx, colour PROM.
// - Drives ioctl_wait as backpressure and holds the game core in load until the final byte lands.
// - Sits between hps_io and core; replaces the raw ioctl wiring into core.

---
 rtl/bp_pkg.sv | 25 ++
 rtl/bp_rom_region_dec.sv | 53 +++++
 rtl/bp_rom_loader.sv | 153 +++++++++++++++
 tb/tb_bp_rom_loader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and default region sizes for the ROM download loader.
package bp_pkg;

  // Destination ROM region of a downloaded byte.
  typedef enum logic [1:0] {
    REG_CPU  = 2'd0,
    REG_GFX1 = 2'd1,
    REG_GFX2 = 2'd2,
    REG_PROM = 2'd3
  } region_t;

  // Loader FSM: idle, writing the low byte, writing the high byte.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } state_t;

  localparam int unsigned ADDR_W        = 27;
  localparam int unsigned CPU_SIZE_DEF  = 32'h0000_E000;
  localparam int unsigned GFX1_SIZE_DEF = 32'h0000_4000;
  localparam int unsigned GFX2_SIZE_DEF = 32'h0000_C000;
  localparam int unsigned PROM_SIZE_DEF = 32'h0000_0220;

endpackage

// File: rtl/bp_rom_region_dec.sv
// Combinational decode of a stream byte address into region and offset.
// Regions are packed back to back: CPU, GFX1, GFX2, PROM.
module bp_rom_region_dec
  import bp_pkg::*;
#(
  parameter int unsigned CPU_SIZE  = CPU_SIZE_DEF,
  parameter int unsigned GFX1_SIZE = GFX1_SIZE_DEF,
  parameter int unsigned GFX2_SIZE = GFX2_SIZE_DEF,
  parameter int unsigned PROM_SIZE = PROM_SIZE_DEF
) (
  input  logic [26:0] i_addr,
  output logic        o_valid,
  output region_t     o_region,
  output logic [15:0] o_rel
);

  // Exclusive end address of each region in the download stream.
  localparam logic [26:0] END_CPU  = 27'(CPU_SIZE);
  localparam logic [26:0] END_GFX1 = 27'(CPU_SIZE + GFX1_SIZE);
  localparam logic [26:0] END_GFX2 = 27'(CPU_SIZE + GFX1_SIZE + GFX2_SIZE);
  localparam logic [26:0] END_PROM = 27'(CPU_SIZE + GFX1_SIZE + GFX2_SIZE + PROM_SIZE);

  logic [26:0] w_base;
  logic [26:0] w_diff;

  assign w_diff = i_addr - w_base;

  // Pick the first region whose end lies above the address.
  always_comb begin
    o_valid  = 1'b0;
    o_region = REG_CPU;
    w_base   = 27'd0;
    if (i_addr < END_CPU) begin
      o_valid  = 1'b1;
      o_region = REG_CPU;
      w_base   = 27'd0;
    end else if (i_addr < END_GFX1) begin
      o_valid  = 1'b1;
      o_region = REG_GFX1;
      w_base   = END_CPU;
    end else if (i_addr < END_GFX2) begin
      o_valid  = 1'b1;
      o_region = REG_GFX2;
      w_base   = END_GFX1;
    end else if (i_addr < END_PROM) begin
      o_valid  = 1'b1;
      o_region = REG_PROM;
      w_base   = END_GFX2;
    end
    o_rel = w_diff[15:0];
  end

endmodule

// File: rtl/bp_rom_loader.sv
// Converts the hps_io 16-bit ROM download stream into routed byte writes.
// Handshake: a word is taken when ioctl_wr is high in IDLE with download
// active on index 0; ioctl_wait is then high for the two byte-write cycles
// and any ioctl_wr seen while it is high is dropped and flagged as overflow.
module bp_rom_loader
  import bp_pkg::*;
#(
  parameter int unsigned CPU_SIZE  = CPU_SIZE_DEF,
  parameter int unsigned GFX1_SIZE = GFX1_SIZE_DEF,
  parameter int unsigned GFX2_SIZE = GFX2_SIZE_DEF,
  parameter int unsigned PROM_SIZE = PROM_SIZE_DEF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [26:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  output logic        loading,
  output logic        done,
  output logic        rom_wr,
  output logic [1:0]  rom_region,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        overflow
);

  state_t      r_state;
  state_t      w_next;
  logic [26:0] r_addr;
  logic [15:0] r_data;
  logic        r_wait;
  logic        r_dl_prev;
  logic        r_loading;
  logic        r_done;
  logic        r_ovf;

  logic        w_dl_ok;
  logic        w_dl_rise;
  logic        w_accept;
  logic        w_drop;
  logic        w_in_word;
  logic [26:0] w_byte_addr;
  logic        w_dec_valid;
  region_t     w_dec_region;
  logic [15:0] w_dec_rel;
  logic        w_byte_wr;
  logic        w_byte_ovf;

  assign w_dl_ok     = ioctl_download && (ioctl_index == 8'd0);
  assign w_dl_rise   = w_dl_ok && !r_dl_prev;
  assign w_accept    = (r_state == ST_IDLE) && ioctl_wr && w_dl_ok;
  assign w_drop      = (r_state != ST_IDLE) && ioctl_wr;
  assign w_in_word   = (r_state == ST_LO) || (r_state == ST_HI);
  assign w_byte_addr = r_addr + 27'(r_state == ST_HI);
  assign w_byte_wr   = w_in_word && w_dec_valid;
  assign w_byte_ovf  = w_in_word && !w_dec_valid;

  bp_rom_region_dec #(
    .CPU_SIZE  (CPU_SIZE),
    .GFX1_SIZE (GFX1_SIZE),
    .GFX2_SIZE (GFX2_SIZE),
    .PROM_SIZE (PROM_SIZE)
  ) u_dec (
    .i_addr   (w_byte_addr),
    .o_valid  (w_dec_valid),
    .o_region (w_dec_region),
    .o_rel    (w_dec_rel)
  );

  // FSM state register; wait is registered from the next state.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_wait  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= (w_next != ST_IDLE);
    end
  end

  // Next-state logic: one accepted word walks LO then HI.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_LO;
      ST_LO:   w_next = ST_HI;
      ST_HI:   w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Byte-write outputs, zeroed whenever no write is issued.
  always_comb begin
    rom_wr     = w_byte_wr;
    rom_region = 2'd0;
    rom_addr   = 16'd0;
    rom_data   = 8'd0;
    if (w_byte_wr) begin
      rom_region = w_dec_region;
      rom_addr   = w_dec_rel;
      rom_data   = (r_state == ST_HI) ? r_data[15:8] : r_data[7:0];
    end
  end

  // Capture the accepted word.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= 27'd0;
      r_data <= 16'd0;
    end else if (w_accept) begin
      r_addr <= ioctl_addr;
      r_data <= ioctl_dout;
    end
  end

  // Loading window and end-of-download pulse.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dl_prev <= 1'b0;
      r_loading <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_dl_prev <= w_dl_ok;
      r_done    <= 1'b0;
      if (w_dl_rise) begin
        r_loading <= 1'b1;
      end else if (r_loading && !ioctl_download && (r_state == ST_IDLE)) begin
        r_loading <= 1'b0;
        r_done    <= 1'b1;
      end
    end
  end

  // Sticky overflow, cleared when a new download starts.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (w_byte_ovf || w_drop) begin
      r_ovf <= 1'b1;
    end else if (w_dl_rise) begin
      r_ovf <= 1'b0;
    end
  end

  assign ioctl_wait = r_wait;
  assign loading    = r_loading;
  assign done       = r_done;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_bp_rom_loader.sv
// Bench for bp_rom_loader: directed boundary words plus random words,
// checked by a byte scoreboard fed from a region-map reference model.
// The PROM is sized 'h21F so the last word straddles the end of the map.
module tb_bp_rom_loader;

  localparam int unsigned CPU_SZ  = 32'hE000;
  localparam int unsigned GFX1_SZ = 32'h4000;
  localparam int unsigned GFX2_SZ = 32'hC000;
  localparam int unsigned PROM_SZ = 32'h021F;
  localparam int unsigned TOTAL   = CPU_SZ + GFX1_SZ + GFX2_SZ + PROM_SZ;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;
  logic        loading;
  logic        done;
  logic        rom_wr;
  logic [1:0]  rom_region;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        overflow;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [25:0] exp_q[$];
  logic [25:0] mon_got;
  logic [25:0] mon_exp;

  bp_rom_loader #(
    .CPU_SIZE  (CPU_SZ),
    .GFX1_SIZE (GFX1_SZ),
    .GFX2_SIZE (GFX2_SZ),
    .PROM_SIZE (PROM_SZ)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .loading        (loading),
    .done           (done),
    .rom_wr         (rom_wr),
    .rom_region     (rom_region),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .overflow       (overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: regions laid end to end, first match wins.
  function automatic void model_byte(input int unsigned a, output bit ok,
                                     output logic [1:0] rg, output logic [15:0] rel);
    int unsigned sizes[4] = '{CPU_SZ, GFX1_SZ, GFX2_SZ, PROM_SZ};
    int unsigned base = 0;
    ok  = 1'b0;
    rg  = 2'd0;
    rel = 16'd0;
    for (int r = 0; r < 4; r++) begin
      if (!ok && a >= base && a < base + sizes[r]) begin
        ok  = 1'b1;
        rg  = 2'(r);
        rel = 16'(a - base);
      end
      base += sizes[r];
    end
  endfunction

  bit exp_ovf = 1'b0;

  // Push the expected byte writes of one word (lo byte first).
  task automatic expect_byte(input int unsigned a, input logic [7:0] b);
    bit ok;
    logic [1:0] rg;
    logic [15:0] rel;
    model_byte(a, ok, rg, rel);
    if (ok) exp_q.push_back({rg, rel, b});
    else exp_ovf = 1'b1;
  endtask

  // Scoreboard monitor: every issued byte write must match the queue head.
  always @(negedge clk_sys) begin
    if (rom_wr) begin
      mon_got = {rom_region, rom_addr, rom_data};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rom_wr actual=%0h required=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rom_byte", 64'(mon_got), 64'(mon_exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [26:0] a, input logic [15:0] d, input logic [7:0] idx);
    int guard = 0;
    @(posedge clk_sys); #1;
    while (ioctl_wait && guard < 20) begin
      @(posedge clk_sys); #1;
      guard++;
    end
    check("wait_released", 64'(ioctl_wait), 64'd0);
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    if (idx == 8'd0 && ioctl_download) begin
      expect_byte(int'(a), d[7:0]);
      expect_byte(int'(a) + 1, d[15:8]);
    end
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic start_download();
    @(posedge clk_sys); #1;
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    exp_ovf        = 1'b0;
    @(posedge clk_sys); #1;
    check("loading_rise", 64'(loading), 64'd1);
    check("overflow_cleared", 64'(overflow), 64'd0);
  endtask

  task automatic wait_loading_fall();
    int guard = 0;
    @(negedge clk_sys);
    while (loading && guard < 10) begin
      @(negedge clk_sys);
      guard++;
    end
    check("loading_fall", 64'(loading), 64'd0);
    check("done_pulse", 64'(done), 64'd1);
    @(negedge clk_sys);
    check("done_single", 64'(done), 64'd0);
  endtask

  task automatic drain_check(input string name);
    repeat (6) @(posedge clk_sys);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = 27'd0;
    ioctl_dout     = 16'd0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("reset_wait", 64'(ioctl_wait), 64'd0);
    check("reset_loading", 64'(loading), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_rom_wr", 64'(rom_wr), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    reset_n = 1'b1;

    // Foreign index: ignored entirely.
    ioctl_index    = 8'd1;
    ioctl_download = 1'b1;
    send(27'h0, 16'h1234, 8'd1);
    check("idx1_wait", 64'(ioctl_wait), 64'd0);
    check("idx1_loading", 64'(loading), 64'd0);
    @(posedge clk_sys); #1;
    ioctl_download = 1'b0;
    check("idx1_loading_later", 64'(loading), 64'd0);

    // Main download with boundary words.
    start_download();
    send(27'h0, 16'hBEEF, 8'd0);
    check("lat_first_byte", 64'(rom_wr), 64'd1);
    check("wait_cycle1", 64'(ioctl_wait), 64'd1);
    @(posedge clk_sys); #1;
    check("wait_cycle2", 64'(ioctl_wait), 64'd1);
    @(posedge clk_sys); #1;
    check("wait_low_after", 64'(ioctl_wait), 64'd0);
    send(27'hDFFE, 16'hA55A, 8'd0);
    send(27'hE000, 16'h0102, 8'd0);
    send(27'h11FFE, 16'h3344, 8'd0);
    send(27'h12000, 16'h5566, 8'd0);
    send(27'h1DFFE, 16'h7788, 8'd0);
    send(27'h1E000, 16'h99AA, 8'd0);
    for (int i = 0; i < 40; i++) begin
      send(27'($urandom_range(0, (TOTAL - 3) / 2) * 2), 16'($urandom), 8'd0);
      repeat ($urandom_range(0, 3)) @(posedge clk_sys);
    end
    drain_check("queue_after_random");
    check("overflow_in_range", 64'(overflow), 64'(exp_ovf));
    send(27'(TOTAL - 1), 16'hC3D4, 8'd0);
    drain_check("queue_after_straddle");
    check("overflow_straddle", 64'(overflow), 64'(exp_ovf));
    send(27'h100, 16'h0F0F, 8'd0);
    drain_check("queue_after_sticky");
    check("overflow_sticky", 64'(overflow), 64'd1);
    @(posedge clk_sys); #1;
    ioctl_download = 1'b0;
    wait_loading_fall();
    check("overflow_after_done", 64'(overflow), 64'd1);

    // Back-to-back strobe: second word dropped, overflow set.
    start_download();
    @(posedge clk_sys); #1;
    ioctl_addr = 27'h200;
    ioctl_dout = 16'h1122;
    ioctl_wr   = 1'b1;
    expect_byte(32'h200, 8'h22);
    expect_byte(32'h201, 8'h11);
    @(posedge clk_sys); #1;
    ioctl_addr = 27'h400;
    ioctl_dout = 16'hFFFF;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    drain_check("queue_after_drop");
    check("overflow_drop", 64'(overflow), 64'd1);

    // Download falls while the low byte is being written.
    send(27'h12340, 16'hCAFE, 8'd0);
    ioctl_download = 1'b0;
    check("fall_lo_active", 64'(rom_wr), 64'd1);
    wait_loading_fall();
    drain_check("queue_after_fall");

    // Reset while the high byte is in flight.
    start_download();
    send(27'h00AA, 16'h6789, 8'd0);
    void'(exp_q.pop_back());
    @(posedge clk_sys); #1;
    reset_n = 1'b0;
    #1;
    check("rst_rom_wr", 64'(rom_wr), 64'd0);
    check("rst_wait", 64'(ioctl_wait), 64'd0);
    check("rst_loading", 64'(loading), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    ioctl_download = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    drain_check("queue_after_reset");
    check("post_reset_loading", 64'(loading), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
